// File: rtl/fixed_p_std_sdiv_pipe.sv
// fixed_p_std_sdiv_pipe
// Sequential signed fixed-point divider with a go/done handshake.
// Restoring long division on operand magnitudes retires one quotient bit
// per cycle. The dividend is pre-scaled by 2^FRACT_WIDTH so the quotient
// keeps the operand format. The sign is applied when the result is written.
module fixed_p_std_sdiv_pipe #(
    parameter int WIDTH       = 32,
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done
);

    // One iteration per bit of the scaled dividend.
    localparam int N  = WIDTH + FRACT_WIDTH;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    // The integer/fraction split has to add up to the operand width.
    if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_bad_split
        $error("INT_WIDTH + FRACT_WIDTH must equal WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]     dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CW-1:0]    iter_cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] left_mag;
    logic [WIDTH-1:0] right_mag;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_signed;
    logic [WIDTH-1:0] rem_signed;

    // State register; reset returns to IDLE and wins over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A zero divisor skips the iterations and goes to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = (right == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (iter_cnt == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One restoring-division step plus operand magnitudes and sign fix-up.
    // The partial remainder always stays below the divisor, so WIDTH bits
    // hold it between steps. Only the shifted value needs the extra bit.
    // Only the low WIDTH quotient bits are kept, because the higher bits
    // would be discarded anyway when the result wraps.
    always_comb begin
        left_mag   = left[WIDTH-1] ? -left : left;
        right_mag  = right[WIDTH-1] ? -right : right;
        rem_shift  = {rem_q, dividend_q[N-1]};
        rem_ge     = (rem_shift >= {1'b0, divisor_q});
        rem_diff   = rem_shift[WIDTH-1:0] - divisor_q;
        rem_next   = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
        quo_next   = (quo_q << 1) | {{(WIDTH-1){1'b0}}, rem_ge};
        quo_signed = sign_q ? -quo_next : quo_next;
        rem_signed = sign_r ? -rem_next : rem_next;
    end

    // Datapath: capture on accepted go, iterate while busy, and publish the
    // signed result on the last iteration so it is visible together with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            dividend_q    <= '0;
            divisor_q     <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            iter_cnt      <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go) begin
                        dividend_q <= {left_mag, {FRACT_WIDTH{1'b0}}};
                        divisor_q  <= right_mag;
                        rem_q      <= '0;
                        quo_q      <= '0;
                        iter_cnt   <= '0;
                        sign_q     <= left[WIDTH-1] ^ right[WIDTH-1];
                        sign_r     <= left[WIDTH-1];
                        if (right == '0) begin
                            out_quotient  <= '0;
                            out_remainder <= left;
                            done          <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    dividend_q <= dividend_q << 1;
                    rem_q      <= rem_next;
                    quo_q      <= quo_next;
                    iter_cnt   <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST_ITER) begin
                        out_quotient  <= quo_signed;
                        out_remainder <= rem_signed;
                        done          <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_p_std_sdiv_pipe.sv
// Testbench for fixed_p_std_sdiv_pipe (Q8.24 defaults).
// It runs table vectors, corner sequences and random operands. The random
// operands are checked against a plain-arithmetic reference model.
module tb_fixed_p_std_sdiv_pipe;

    localparam int LAT      = 57;
    localparam int MAX_WAIT = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] q;
        logic [31:0] rem;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    fixed_p_std_sdiv_pipe #(
        .WIDTH(32),
        .INT_WIDTH(8),
        .FRACT_WIDTH(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .go(go),
        .left(left),
        .right(right),
        .out_quotient(out_quotient),
        .out_remainder(out_remainder),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present operands with a one-cycle go pulse; returns on the negedge after the accepting edge.
    task automatic applyStimulus(input logic [31:0] l, input logic [31:0] r);
        @(negedge clk);
        left  = l;
        right = r;
        go    = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic waitDone(input int start_lat, output int lat);
        lat = start_lat;
        while (!done && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Reference: scaled integer division of magnitudes, then sign fix-up.
    task automatic refModel(input logic [31:0] l, input logic [31:0] r,
                            output logic [31:0] q, output logic [31:0] rm);
        logic [63:0] lm, rmag, qq, rr, nq, nr;
        if (r == 32'd0) begin
            q  = 32'd0;
            rm = l;
        end else begin
            lm   = {32'd0, (l[31] ? (32'd0 - l) : l)};
            rmag = {32'd0, (r[31] ? (32'd0 - r) : r)};
            qq   = (lm << 24) / rmag;
            rr   = (lm << 24) % rmag;
            nq   = 64'd0 - qq;
            nr   = 64'd0 - rr;
            q    = (l[31] ^ r[31]) ? nq[31:0] : qq[31:0];
            rm   = l[31] ? nr[31:0] : rr[31:0];
        end
    endtask

    task automatic runOp(input string name, input logic [31:0] l, input logic [31:0] r,
                         input logic [31:0] eq, input logic [31:0] er, input int elat);
        int lat;
        applyStimulus(l, r);
        waitDone(1, lat);
        checkOutput({name, "_lat"}, 32'(lat), 32'(elat));
        checkOutput({name, "_q"}, out_quotient, eq);
        checkOutput({name, "_r"}, out_remainder, er);
        @(negedge clk);
        checkOutput({name, "_done_drop"}, {31'd0, done}, 32'd0);
        checkOutput({name, "_q_hold"}, out_quotient, eq);
    endtask

    initial begin
        int          lat;
        int          done_cnt;
        logic [31:0] l, r, eq, er;
        logic [31:0] held_q;

        vecs[0]  = '{"six_by_two",     32'h06000000, 32'h02000000, 32'h03000000, 32'h00000000, LAT};
        vecs[1]  = '{"neg7p5_by_2",    32'hF8800000, 32'h02000000, 32'hFC400000, 32'h00000000, LAT};
        vecs[2]  = '{"7p5_by_neg2",    32'h07800000, 32'hFE000000, 32'hFC400000, 32'h00000000, LAT};
        vecs[3]  = '{"one_by_three",   32'h01000000, 32'h03000000, 32'h00555555, 32'h01000000, LAT};
        vecs[4]  = '{"neg1_by_three",  32'hFF000000, 32'h03000000, 32'hFFAAAAAB, 32'hFF000000, LAT};
        vecs[5]  = '{"div_zero",       32'h01000000, 32'h00000000, 32'h00000000, 32'h01000000, 1};
        vecs[6]  = '{"minneg_by_neg1", 32'h80000000, 32'hFF000000, 32'h80000000, 32'h00000000, LAT};
        vecs[7]  = '{"minneg_by_self", 32'h80000000, 32'h80000000, 32'h01000000, 32'h00000000, LAT};
        vecs[8]  = '{"minneg_by_one",  32'h80000000, 32'h01000000, 32'h80000000, 32'h00000000, LAT};
        vecs[9]  = '{"tiny_by_max",    32'h00000001, 32'h7FFFFFFF, 32'h00000000, 32'h01000000, LAT};
        vecs[10] = '{"max_by_tiny",    32'h7FFFFFFF, 32'h00000001, 32'hFF000000, 32'h00000000, LAT};
        vecs[11] = '{"zero_by_five",   32'h00000000, 32'h05000000, 32'h00000000, 32'h00000000, LAT};

        reset = 1'b1;
        go    = 1'b0;
        left  = 32'd0;
        right = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_q", out_quotient, 32'd0);
        checkOutput("reset_r", out_remainder, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            runOp(vecs[i].name, vecs[i].l, vecs[i].r, vecs[i].q, vecs[i].rem, vecs[i].lat);
        end

        // Reset in the middle of an operation aborts it without a done pulse.
        applyStimulus(32'h06000000, 32'h02000000);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_q", out_quotient, 32'd0);
        checkOutput("abort_r", out_remainder, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
        runOp("after_abort", 32'h06000000, 32'h02000000, 32'h03000000, 32'h00000000, LAT);

        // A go pulse with new operands while busy must be ignored.
        applyStimulus(32'h01000000, 32'h03000000);
        repeat (9) @(negedge clk);
        left  = 32'h06000000;
        right = 32'h00000000;
        go    = 1'b1;
        @(negedge clk);
        go = 1'b0;
        waitDone(11, lat);
        checkOutput("busy_go_lat", 32'(lat), 32'(LAT));
        checkOutput("busy_go_q", out_quotient, 32'h00555555);
        checkOutput("busy_go_r", out_remainder, 32'h01000000);

        // go held high: back-to-back operations every N+2 cycles.
        @(negedge clk);
        left     = 32'h06000000;
        right    = 32'h02000000;
        go       = 1'b1;
        done_cnt = 0;
        held_q   = out_quotient;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) checkOutput("held_first_lat", 32'(k), 32'd57);
                if (done_cnt == 2) checkOutput("held_second_lat", 32'(k), 32'd115);
                checkOutput("held_q", out_quotient, 32'h03000000);
                held_q = 32'h03000000;
            end else begin
                checkOutput("held_stable", out_quotient, held_q);
            end
        end
        go = 1'b0;
        checkOutput("held_done_count", 32'(done_cnt), 32'd2);
        waitDone(0, lat);
        checkOutput("held_third_q", out_quotient, 32'h03000000);
        @(negedge clk);

        // Random operands against the reference model.
        for (int i = 0; i < 30; i++) begin
            l = $urandom;
            case ($urandom_range(0, 3))
                0:       r = $urandom;
                1:       r = 32'($urandom_range(1, 255)) << $urandom_range(16, 28);
                2:       r = 32'($urandom_range(0, 2));
                default: r = 32'd0 - (32'($urandom_range(1, 4095)) << $urandom_range(12, 24));
            endcase
            refModel(l, r, eq, er);
            runOp("rand", l, r, eq, er, (r == 32'd0) ? 1 : LAT);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixed_p_std_sdiv_pipe.md
# fixed_p_std_sdiv_pipe

Multi-cycle signed fixed-point divider for the fixed-point primitive library, using the go/done protocol the compiler emits for sequential primitives. It is the sequential counterpart to the signed fixed-point multiply path: one quotient bit per cycle via restoring long division on magnitudes, sign fixed up at the end. It serves designs where a single-cycle divider does not close timing.

## Interface
- WIDTH, 32, total operand/result width (two's complement)
- INT_WIDTH, 8, integer bits; WIDTH = INT_WIDTH + FRACT_WIDTH
- FRACT_WIDTH, 24, fractional bits
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- go  input  1  start request; sampled only in IDLE
- left  input  WIDTH  signed dividend, Q(INT_WIDTH).(FRACT_WIDTH); captured on accepted go
- right  input  WIDTH  signed divisor, same format; captured on accepted go
- out_quotient  output  WIDTH  signed quotient, same format; registered
- out_remainder  output  WIDTH  signed remainder of the scaled division; registered
- done  output  1  one-cycle pulse, results valid

## Operation
- N = WIDTH + FRACT_WIDTH iterations.
- States: IDLE, BUSY, DONE.
- IDLE: go=1 → capture |left|, |right| as WIDTH-bit unsigned magnitudes, sign_q = left[MSB]^right[MSB], sign_r = left[MSB]; load N-bit dividend register = |left| << FRACT_WIDTH; clear partial remainder (WIDTH+1 bits) and iteration counter; → BUSY. Special case right==0: → DONE directly, no iterations.
- BUSY, per cycle: shift partial remainder left by 1, bringing in dividend MSB; if partial remainder ≥ |right|, subtract and shift quotient bit 1, else 0. After N iterations → DONE.
- DONE: write outputs; done=1 for this cycle only; → IDLE.
- Quotient: low WIDTH bits of the N-bit magnitude quotient, negated if sign_q. Truncation toward zero. Overflow wraps (no saturation).
- Remainder: final partial remainder (< |right|, fits WIDTH bits unsigned), negated if sign_r.
- Most negative operand (-2^(WIDTH-1)): magnitude is 2^(WIDTH-1) unsigned. Must be handled exactly.
- Divide by zero: out_quotient = 0, out_remainder = left.
- go in BUSY or DONE is ignored. go held high through DONE starts a new operation in the following IDLE cycle.
- Outputs hold their last result until the next DONE or reset.

## Timing
- Reset: state=IDLE; out_quotient=0, out_remainder=0, done=0; internal registers cleared.
- go=1 in IDLE at cycle t → BUSY cycles t+1..t+N → done=1 and new outputs visible in cycle t+N+1. Latency N+1 (57 at defaults).
- Divide by zero: go at t → done at t+1.
- Minimum go-to-go spacing: N+2 cycles (go held high continuously).
- reset in any cycle aborts the operation: next cycle is IDLE with outputs zeroed, and done is not asserted for the aborted operation. Reset has priority over go in the same cycle.

## Test plan
Defaults: WIDTH=32, INT_WIDTH=8, FRACT_WIDTH=24 (Q8.24).
- left=0x06000000 (6.0), right=0x02000000 (2.0), go at t → done only at t+57; out_quotient=0x03000000, out_remainder=0.
- left=0xF8800000 (-7.5), right=0x02000000 → out_quotient=0xFC400000 (-3.75), out_remainder=0. Swapping signs (7.5 / -2.0) gives the same quotient.
- left=0x01000000 (1.0), right=0x03000000 (3.0) → out_quotient=0x00555555, out_remainder=0x01000000. left=0xFF000000 (-1.0), same right → out_quotient=0xFFAAAAAB, out_remainder=0xFF000000.
- left=0x01000000, right=0 → done at t+1; out_quotient=0, out_remainder=0x01000000. left=0x80000000, right=0xFF000000 (-1.0) → wrapped quotient 0x80000000, no hang.
- reset asserted at t+20 of an operation → done stays 0, outputs 0; new go after reset with 6.0/2.0 yields 0x03000000 at the correct latency.
- go held high for 120 cycles with constant operands → done at t+57 and t+115; go pulses during BUSY are ignored, and outputs are stable between pulses.
